// File: rtl/mul_issue_pkg.sv
// Shared encodings for the EX-stage multiply issue block: operation codes
// from EX and the issue FSM state constants.
package mul_issue_pkg;

  typedef enum logic [1:0] {
    MUL_OP_NONE  = 2'b00,
    MUL_OP_MULT  = 2'b01,
    MUL_OP_MULTU = 2'b10,
    MUL_OP_MUL   = 2'b11
  } mul_op_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_CANCEL = 2'd3;

  // MULT and MUL are signed; MULTU is the only unsigned form.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MUL_OP_MULT) || (op == MUL_OP_MUL);
  endfunction

  function automatic logic op_is_gpr(input logic [1:0] op);
    return op == MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/mul_issue_if.sv
// Signal bundle between mul_issue and its neighbours: EX stage, iterative
// multiplier, HI/LO register and pipeline control.
interface mul_issue_if;
  // EX stage side
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        flush_i;
  logic        stallreq_o;
  // multiplier side
  logic        mul_start_o;
  logic        mul_annul_o;
  logic        mul_signed_o;
  logic [31:0] mul_opdata1_o;
  logic [31:0] mul_opdata2_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;
  // writeback side
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        gpr_valid_o;
  logic        timeout_o;

  // issue block view
  modport slave (
    input  op_i, opdata1_i, opdata2_i, flush_i, mul_result_i, mul_ready_i,
    output stallreq_o, mul_start_o, mul_annul_o, mul_signed_o,
           mul_opdata1_o, mul_opdata2_o, hilo_we_o, hi_o, lo_o,
           gpr_valid_o, timeout_o
  );

  // surrounding pipeline / multiplier view
  modport master (
    output op_i, opdata1_i, opdata2_i, flush_i, mul_result_i, mul_ready_i,
    input  stallreq_o, mul_start_o, mul_annul_o, mul_signed_o,
           mul_opdata1_o, mul_opdata2_o, hilo_we_o, hi_o, lo_o,
           gpr_valid_o, timeout_o
  );
endinterface

// File: rtl/mul_issue.sv
// EX-stage initiator for the iterative multiplier: latches operands, holds
// start until ready, and retires the product to HI/LO or the GPR path.
module mul_issue
  import mul_issue_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic      clk,
  input  logic      rst,
  mul_issue_if.slave bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_gpr;
  logic             start_q;
  logic             signed_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic             hilo_we_q;
  logic             gpr_valid_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             timeout_q;

  logic issue;
  logic in_wait;
  logic expire;

  assign issue   = (state == ST_IDLE) && (bus.op_i != MUL_OP_NONE) && !bus.flush_i;
  assign in_wait = (state == ST_WAIT);
  // a ready arriving on the last allowed cycle still wins over the watchdog
  assign expire  = in_wait && (cnt == CNT_W'(TIMEOUT - 1)) && !bus.mul_ready_i;

  // annul is a single-cycle pulse in the WAIT cycle that decides to abort
  assign bus.mul_annul_o = in_wait && (bus.flush_i || expire);
  // held low during reset so a reset mid-op never leaves the pipe stalled
  assign bus.stallreq_o  = rst && (issue || in_wait);

  assign bus.mul_start_o   = start_q;
  assign bus.mul_signed_o  = signed_q;
  assign bus.mul_opdata1_o = opa_q;
  assign bus.mul_opdata2_o = opb_q;
  assign bus.hilo_we_o     = hilo_we_q;
  assign bus.gpr_valid_o   = gpr_valid_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  assign bus.timeout_o     = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_gpr      <= 1'b0;
      start_q     <= 1'b0;
      signed_q    <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      hilo_we_q   <= 1'b0;
      gpr_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      hilo_we_q   <= 1'b0;
      gpr_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            opa_q    <= bus.opdata1_i;
            opb_q    <= bus.opdata2_i;
            signed_q <= op_is_signed(bus.op_i);
            is_gpr   <= op_is_gpr(bus.op_i);
            start_q  <= 1'b1;
            cnt      <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.flush_i) begin
            start_q <= 1'b0;
            state   <= ST_CANCEL;
          end else if (expire) begin
            timeout_q <= 1'b1;
            start_q   <= 1'b0;
            state     <= ST_CANCEL;
          end else if (bus.mul_ready_i) begin
            hi_q        <= bus.mul_result_i[63:32];
            lo_q        <= bus.mul_result_i[31:0];
            hilo_we_q   <= !is_gpr;
            gpr_valid_q <= is_gpr;
            start_q     <= 1'b0;
            state       <= ST_DONE;
          end
        end
        // the retiring instruction is still on op_i, so DONE never reissues
        ST_DONE:   state <= ST_IDLE;
        ST_CANCEL: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue with a behavioural 13-cycle multiplier.
module tb_mul_issue;
  import mul_issue_pkg::*;

  localparam int LAT = 13;
  localparam int TMO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mul_en = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mul_issue_if bus();

  mul_issue #(.TIMEOUT(TMO), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  // behavioural multiplier: ready in the LAT-th cycle of start being high
  logic [5:0]  mcnt;
  logic [63:0] ea, eb;
  always @(posedge clk) begin
    if (!bus.mul_start_o) mcnt <= '0;
    else if (mcnt != 6'(LAT - 1)) mcnt <= mcnt + 6'd1;
  end
  assign ea = bus.mul_signed_o ? {{32{bus.mul_opdata1_o[31]}}, bus.mul_opdata1_o}
                               : {32'd0, bus.mul_opdata1_o};
  assign eb = bus.mul_signed_o ? {{32{bus.mul_opdata2_o[31]}}, bus.mul_opdata2_o}
                               : {32'd0, bus.mul_opdata2_o};
  assign bus.mul_result_i = ea * eb;
  assign bus.mul_ready_i  = mul_en && bus.mul_start_o && (mcnt == 6'(LAT - 1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge inside the DONE cycle with op_i
  // still driven, so the caller may chain the next op back-to-back.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_sgn, input bit scramble);
    int  cyc = 0;
    int  st = 0;
    bit  done = 0;
    bit  stall_ok = 1;
    bit  hold_ok = 1;
    bit  sgn_ok = 1;
    bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.mul_start_o) begin
        st++;
        if (bus.stallreq_o !== 1'b1) stall_ok = 0;
        if (bus.mul_opdata1_o !== a || bus.mul_opdata2_o !== b) hold_ok = 0;
        if (bus.mul_signed_o !== exp_sgn) sgn_ok = 0;
        if (scramble) begin
          bus.opdata1_i = ~a ^ 32'(cyc);
          bus.opdata2_i = ~b;
        end
      end
      if (bus.hilo_we_o || bus.gpr_valid_o) done = 1;
    end
    chk({tag, "_done"},      64'(done), 64'(1));
    chk({tag, "_start_cyc"}, 64'(st), 64'(LAT));
    chk({tag, "_stall"},     64'(stall_ok), 64'(1));
    chk({tag, "_hold"},      64'(hold_ok), 64'(1));
    chk({tag, "_signed"},    64'(sgn_ok), 64'(1));
    chk({tag, "_hilo_we"},   64'(bus.hilo_we_o), 64'(op != MUL_OP_MUL));
    chk({tag, "_gpr_valid"}, 64'(bus.gpr_valid_o), 64'(op == MUL_OP_MUL));
    chk({tag, "_hi"},        64'(bus.hi_o), 64'(exp_hi));
    chk({tag, "_lo"},        64'(bus.lo_o), 64'(exp_lo));
    chk({tag, "_done_start"}, 64'(bus.mul_start_o), 64'(0));
    chk({tag, "_done_stall"}, 64'(bus.stallreq_o), 64'(0));
  endtask

  // one cycle later with op_i cleared: strobes must have been single-cycle
  task automatic settle(input string tag);
    bus.op_i = MUL_OP_NONE;
    @(negedge clk);
    chk({tag, "_we_pulse"},  64'(bus.hilo_we_o), 64'(0));
    chk({tag, "_gpr_pulse"}, 64'(bus.gpr_valid_o), 64'(0));
  endtask

  initial begin
    int c;
    bus.op_i = MUL_OP_NONE; bus.opdata1_i = '0; bus.opdata2_i = '0; bus.flush_i = 1'b0;

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_start",   64'(bus.mul_start_o), 64'(0));
    chk("rst_annul",   64'(bus.mul_annul_o), 64'(0));
    chk("rst_signed",  64'(bus.mul_signed_o), 64'(0));
    chk("rst_opa",     64'(bus.mul_opdata1_o), 64'(0));
    chk("rst_opb",     64'(bus.mul_opdata2_o), 64'(0));
    chk("rst_stall",   64'(bus.stallreq_o), 64'(0));
    chk("rst_we",      64'(bus.hilo_we_o), 64'(0));
    chk("rst_gpr",     64'(bus.gpr_valid_o), 64'(0));
    chk("rst_hilo",    64'({bus.hi_o, bus.lo_o}), 64'(0));
    chk("rst_timeout", 64'(bus.timeout_o), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // signed MULT -2 x 3; stall is combinational in the issuing IDLE cycle
    bus.op_i = MUL_OP_MULT; bus.opdata1_i = 32'hFFFF_FFFE; bus.opdata2_i = 32'd3;
    #1 chk("mult_issue_stall", 64'(bus.stallreq_o), 64'(1));
    issue("mult", MUL_OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0);
    settle("mult");

    // unsigned MULTU max x max
    issue("multu", MUL_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    settle("multu");

    // MUL to GPR
    issue("mul", MUL_OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, 1'b0);
    settle("mul");

    // flush in WAIT cycle 5
    bus.op_i = MUL_OP_MULT; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd9;
    repeat (5) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_annul",  64'(bus.mul_annul_o), 64'(1));
    chk("flush_start",  64'(bus.mul_start_o), 64'(1));
    @(negedge clk);
    bus.flush_i = 1'b0; bus.op_i = MUL_OP_NONE;
    chk("cancel_annul", 64'(bus.mul_annul_o), 64'(0));
    chk("cancel_start", 64'(bus.mul_start_o), 64'(0));
    chk("cancel_stall", 64'(bus.stallreq_o), 64'(0));
    chk("cancel_we",    64'(bus.hilo_we_o | bus.gpr_valid_o), 64'(0));
    @(negedge clk);
    chk("cancel_idle_start", 64'(bus.mul_start_o), 64'(0));
    chk("cancel_idle_we",    64'(bus.hilo_we_o | bus.gpr_valid_o), 64'(0));
    issue("after_flush", MUL_OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, 1'b0);
    settle("after_flush");

    // back-to-back with EX operands changing during WAIT
    issue("b2b_1", MUL_OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 1'b1);
    issue("b2b_2", MUL_OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, 1'b1, 1'b1);
    settle("b2b_2");

    // watchdog: multiplier never ready
    mul_en = 1'b0;
    bus.op_i = MUL_OP_MULTU; bus.opdata1_i = 32'd1; bus.opdata2_i = 32'd1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.mul_annul_o && c < 60);
    chk("wd_cycle",      64'(c), 64'(TMO));
    chk("wd_pre_flag",   64'(bus.timeout_o), 64'(0));
    @(negedge clk);
    bus.op_i = MUL_OP_NONE;
    chk("wd_flag",       64'(bus.timeout_o), 64'(1));
    chk("wd_annul_off",  64'(bus.mul_annul_o), 64'(0));
    chk("wd_start",      64'(bus.mul_start_o), 64'(0));
    chk("wd_no_strobe",  64'(bus.hilo_we_o | bus.gpr_valid_o), 64'(0));
    @(negedge clk);
    chk("wd_sticky",     64'(bus.timeout_o), 64'(1));
    mul_en = 1'b1;

    // async reset mid-WAIT, sampled between clock edges
    bus.op_i = MUL_OP_MULT; bus.opdata1_i = 32'd2; bus.opdata2_i = 32'd2;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_start",   64'(bus.mul_start_o), 64'(0));
    chk("arst_stall",   64'(bus.stallreq_o), 64'(0));
    chk("arst_signed",  64'(bus.mul_signed_o), 64'(0));
    chk("arst_opa",     64'(bus.mul_opdata1_o), 64'(0));
    chk("arst_hilo",    64'({bus.hi_o, bus.lo_o}), 64'(0));
    chk("arst_timeout", 64'(bus.timeout_o), 64'(0));
    bus.op_i = MUL_OP_NONE;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_start", 64'(bus.mul_start_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
Name: mul_issue

Overview:
- EX-stage initiator for the iterative multiplier: accepts MULT/MULTU/MUL from EX, holds operands stable, and drives the multiplier's start/annul/signed handshake.
- Stalls the pipeline until the multiplier reports ready, then delivers the 64-bit product as a HI/LO write or a GPR low-word result.
- Sits between the EX stage, the multiplier, the HI/LO register and the pipeline control (stall/flush) logic.

Parameters:
- TIMEOUT, 32, maximum WAIT cycles before the watchdog aborts the operation (must be ≥ multiplier latency + 2).
- CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- op_i  input  2  operation from EX: 00 none, 01 MULT, 10 MULTU, 11 MUL
- opdata1_i  input  32  rs operand from EX
- opdata2_i  input  32  rt operand from EX
- flush_i  input  1  pipeline flush (exception/eret); kills the EX instruction
- mul_start_o  output  1  multiplier start, held high until the result is taken
- mul_annul_o  output  1  multiplier cancel
- mul_signed_o  output  1  1 = signed multiply
- mul_opdata1_o  output  32  latched operand A
- mul_opdata2_o  output  32  latched operand B
- mul_result_i  input  64  multiplier product
- mul_ready_i  input  1  multiplier result valid
- stallreq_o  output  1  stall request to pipeline control
- hilo_we_o  output  1  one-cycle HI/LO write strobe
- hi_o  output  32  product [63:32]
- lo_o  output  32  product [31:0]
- gpr_valid_o  output  1  one-cycle strobe: lo_o is the MUL GPR result
- timeout_o  output  1  sticky watchdog error flag

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All registered outputs are 0, as are the operand latches and the counter.
  - Reset mid-operation abandons the op; start is low at reset release, so the multiplier returns to idle.
- States: IDLE, WAIT, DONE, CANCEL.
- IDLE:
  - When op_i ≠ 00 and flush_i = 0: latch opdata1_i, opdata2_i and signed = (op_i == 01 or 11) into the mul_* registers.
  - Latch the op kind, set mul_start_o = 1, clear the counter, go to WAIT.
  - Otherwise stay in IDLE with mul_start_o = 0.
- WAIT:
  - mul_start_o = 1 and the counter increments each cycle.
  - Operands are held stable: the multiplier samples them continuously, so the latches must not change until DONE.
  - Priority order:
    1. flush_i = 1: pulse mul_annul_o = 1 for one cycle, set mul_start_o = 0, go to CANCEL.
    2. Counter == TIMEOUT-1 with no ready: set timeout_o = 1 (sticky until reset), annul as above, go to CANCEL.
    3. mul_ready_i = 1: capture mul_result_i into hi_o/lo_o, set mul_start_o = 0, go to DONE.
- DONE (exactly 1 cycle):
  - hilo_we_o = 1 for MULT/MULTU; gpr_valid_o = 1 for MUL (hi_o/lo_o still loaded, hilo_we_o = 0).
  - stallreq_o = 0, so the EX instruction advances at the end of this cycle.
  - op_i is ignored here, because the same instruction is still present.
  - mul_start_o = 0 this cycle, which guarantees the multiplier sees start low and returns to idle before the next issue.
  - Next state IDLE; the strobes are 0 in IDLE.
- CANCEL (exactly 1 cycle):
  - mul_start_o = 0, mul_annul_o = 0, stallreq_o = 0, no write strobes.
  - Next state IDLE.
  - The killed instruction never writes HI/LO or the GPR.
- stallreq_o is combinational: (IDLE && op_i ≠ 00 && !flush_i) || WAIT.
- Back-to-back multiplies: the second op is accepted in the IDLE cycle after DONE. Minimum issue spacing is multiplier latency + 2 cycles.
- Simultaneous events:
  - flush_i and mul_ready_i together in WAIT: flush wins, and the product is discarded.
  - flush_i in DONE: the strobes still fire, because that instruction already committed.
- No latency assumption: correctness must not depend on the multiplier's cycle count.

Decomposition:
- Shared package: op encodings (MUL_OP_NONE/MULT/MULTU/MUL) and state encodings (2 bits).
- Keep TIMEOUT as a parameter, not a package constant.
- No sub-module; the watchdog counter stays inline.

Test Plan:
- Signed issue/retire: MULT, opdata1 = 0xFFFFFFFE (−2), opdata2 = 0x00000003, behavioural multiplier with 13-cycle latency.
  - Required: start high for 13 cycles, stall high throughout.
  - Then exactly one hilo_we pulse with hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
- Unsigned issue/retire: MULTU, 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: signed = 0, hi = 0xFFFFFFFE, lo = 0x00000001.
- MUL to GPR: MUL, 7 × 6.
  - Required: gpr_valid one-cycle pulse, lo = 42, hilo_we stays 0.
- Flush mid-operation: flush at WAIT cycle 5.
  - Required: annul one-cycle pulse, start falls, CANCEL then IDLE, no strobes.
  - A following MULT 2×3 completes with lo = 6.
- Back-to-back with operand change: two MULTs (3×4, then 5×5) with EX operands changing while in WAIT.
  - Required: results 12 then 25.
  - Start low for at least 1 cycle between issues; latched operands do not track EX.
- Watchdog and reset:
  - Multiplier never asserts ready: at TIMEOUT the block annuls and timeout_o latches high.
  - Async rst low mid-WAIT: all outputs go to 0 immediately, without waiting for a clock edge.
